// File: rtl/btn_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner_pkg
// Description : Shared definitions for the button conditioner: button index
//               constants, the per-channel debounce state type and counter
//               width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_conditioner_pkg;

  // Bit positions of the board buttons inside the btn_* vectors.
  localparam int BTN_IDX_UP   = 0;
  localparam int BTN_IDX_DN   = 1;
  localparam int BTN_IDX_BACK = 2;
  localparam int BTN_IDX_OK   = 3;
  localparam int BTN_IDX_INT  = 4;

  // Debounce state doubles as the debounced level (PRESSED = 1).
  typedef enum logic [0:0] {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : btn_conditioner_pkg
`default_nettype wire

// File: rtl/btn_conditioner_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner_ch
// Description : One button channel: 2-FF synchroniser, tick-based debounce
//               FSM, registered press/release strobes and, when the macro
//               BTN_CONDITIONER_AUTOREPEAT_EN is defined, auto-repeat strobes.
// Ports       : clk_i, rst_i (async, active high), tick_i (shared prescaler
//               tick), raw_i (pad level), level_o (debounced, 1 = pressed),
//               press_o / release_o / repeat_o (single-cycle strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner_ch
  import btn_conditioner_pkg::*;
#(
  parameter int ACTIVE_LOW     = 1,
  parameter int DEBOUNCE_TICKS = 10
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int              DB_W      = cnt_width(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic            PAD_IDLE  = (ACTIVE_LOW != 0);

  logic            sync1_q, sync2_q;
  logic            pressed_sync;
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Synchroniser; flops come out of reset at the released pad level so no
  // spurious change is seen when reset is removed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= PAD_IDLE;
      sync2_q <= PAD_IDLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_sync = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DB_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: the counter holds the number of ticks seen while the synced
  // input continuously differed from the debounced level. Acceptance happens
  // on the tick that would bring it to DEBOUNCE_TICKS, so it never exceeds
  // DEBOUNCE_TICKS-1 and cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (pressed_sync == (state_q == DB_PRESSED)) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q >= DB_LAST) begin
        accept  = 1'b1;
        cnt_d   = '0;
        state_d = (state_q == DB_PRESSED) ? DB_RELEASED : DB_PRESSED;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    press_d   = accept && (state_q == DB_RELEASED);
    release_d = accept && (state_q == DB_PRESSED);
  end

  assign level_o   = (state_q == DB_PRESSED);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int              HOLD_W     = cnt_width(max_int(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS) + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_TICKS - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              started_q, started_d;
  logic              repeat_q, repeat_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q    <= '0;
      started_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      started_q <= started_d;
      repeat_q  <= repeat_d;
    end
  end

  // Any acceptance (press or release) clears the hold count, which also keeps
  // a repeat from landing in the same cycle as a press/release strobe.
  always_comb begin
    hold_d    = hold_q;
    started_d = started_q;
    repeat_d  = 1'b0;
    if ((state_q != DB_PRESSED) || accept) begin
      hold_d    = '0;
      started_d = 1'b0;
    end else if (tick_i) begin
      if (hold_q == (started_q ? RATE_LAST : DELAY_LAST)) begin
        hold_d    = '0;
        started_d = 1'b1;
        repeat_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule : btn_conditioner_ch
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_conditioner
// Description : Conditions NUM_BTN raw button pads into clean debounced levels
//               with press/release strobes. Contains the shared debounce tick
//               prescaler and one btn_conditioner_ch per button.
//               Auto-repeat strobes are built only when the macro
//               BTN_CONDITIONER_AUTOREPEAT_EN is defined; otherwise
//               btn_repeat is tied to 0.
// Ports       : core_clk, core_rst (async, active high), btn_raw (pads),
//               btn_level, btn_press, btn_release, btn_repeat.
//               Bit order: UP, DN, BACK, OK, INTERRUPT.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NUM_BTN            = 5,
  parameter int ACTIVE_LOW         = 1,
  parameter int TICK_DIV           = 24000,
  parameter int DEBOUNCE_TICKS     = 10,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic               core_clk,
  input  logic               core_rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int                    TICK_W    = cnt_width(TICK_DIV);
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 ||
      REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_cfg
    $error("btn_conditioner: parameter out of range");
  end

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Shared prescaler: counts 0..TICK_DIV-1, tick on the last count.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_conditioner_ch #(
      .ACTIVE_LOW         (ACTIVE_LOW),
      .DEBOUNCE_TICKS     (DEBOUNCE_TICKS)
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
`endif
    ) u_ch (
      .clk_i     (core_clk),
      .rst_i     (core_rst),
      .tick_i    (tick),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .repeat_o  (btn_repeat[i])
    );
  end

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Self-checking bench for btn_conditioner (TICK_DIV=4,
//               DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2,
//               ACTIVE_LOW=1). A behavioural model predicts every output each
//               cycle; directed scenarios add literal timing expectations.
//               Auto-repeat expectations follow BTN_CONDITIONER_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int NB = 5;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] raw = '1;
  logic [NB-1:0] level, press, rel, rpt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN(NB), .ACTIVE_LOW(1), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY_TICKS(RD), .REPEAT_RATE_TICKS(RR)
  ) dut (
    .core_clk(clk), .core_rst(rst), .btn_raw(raw),
    .btn_level(level), .btn_press(press), .btn_release(rel), .btn_repeat(rpt)
  );

  // ---------------- behavioural model ----------------
  // Raw pad seen two edges late; a change is accepted on the DB-th tick of
  // an unbroken run of disagreement between the pad and the accepted level.
  logic [NB-1:0] pad_d1 = '1, pad_d2 = '1;
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rpt = '0;
  int            m_cycle = 0;
  int            m_run [NB];
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  int            m_hold [NB];
  bit            m_started [NB];
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_d1 = '1; pad_d2 = '1;
      m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0;
      m_cycle = 0;
      for (int c = 0; c < NB; c++) begin
        m_run[c] = 0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        m_hold[c] = 0; m_started[c] = 0;
`endif
      end
    end else begin
      bit            tick;
      logic [NB-1:0] pressed_now;
      logic [NB-1:0] lvl_old;
      tick        = ((m_cycle % TD) == TD - 1);
      m_cycle     = m_cycle + 1;
      pressed_now = ~pad_d2;
      pad_d2      = pad_d1;
      pad_d1      = raw;
      lvl_old     = m_level;
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int c = 0; c < NB; c++) begin
        bit acc;
        acc = 0;
        if (pressed_now[c] == lvl_old[c]) m_run[c] = 0;
        else if (tick) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DB) begin
            acc        = 1;
            m_run[c]   = 0;
            m_level[c] = ~lvl_old[c];
            if (lvl_old[c]) m_rel[c] = 1'b1; else m_press[c] = 1'b1;
          end
        end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        if (!lvl_old[c] || acc) begin
          m_hold[c] = 0; m_started[c] = 0;
        end else if (tick) begin
          m_hold[c] = m_hold[c] + 1;
          if (m_hold[c] == (m_started[c] ? RR : RD)) begin
            m_rpt[c] = 1'b1; m_hold[c] = 0; m_started[c] = 1;
          end
        end
`else
        if (acc) m_rpt[c] = 1'b0;
`endif
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk_vec(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d..%0d", nm, $time, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    chk_vec("level",   level,       m_level);
    chk_vec("press",   press,       m_press);
    chk_vec("release", rel,         m_rel);
    chk_vec("repeat",  rpt,         m_rpt);
    chk_vec("excl",    press & rel, '0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // which: 0 = press, 1 = release, 2 = repeat. n = edges until seen (or limit).
  task automatic wait_strobe(input int which, input logic [NB-1:0] mask, input int limit, output int n);
    logic [NB-1:0] v;
    n = 0;
    do begin
      step(1);
      n++;
      v = (which == 0) ? press : (which == 1) ? rel : rpt;
    end while (((v & mask) == '0) && n < limit);
  endtask

  int n, cnt, first;

  initial begin
    // Reset with all pads pressed; no strobe on release, full debounce after.
    raw = '0;
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    wait_strobe(0, '1, 40, n);
    chk_range("rst_press_latency", n, 12, 12);
    chk_vec("rst_press_all", press, 5'b11111);
    step(1);
    chk_vec("rst_level_all", level, 5'b11111);
    chk_vec("rst_press_single", press, 5'b00000);

    raw = '1;
    wait_strobe(1, '1, 40, n);
    chk_range("rel_all_latency", n, 11, 14);
    step(10);

    // Clean press / release on OK.
    raw[3] = 1'b0;
    wait_strobe(0, 5'b01000, 40, n);
    chk_range("ok_press_latency", n, 11, 14);
    chk_vec("ok_press_vec", press, 5'b01000);
    raw[3] = 1'b1;
    wait_strobe(1, 5'b01000, 40, n);
    chk_range("ok_release_latency", n, 11, 14);
    chk_vec("ok_release_vec", rel, 5'b01000);
    step(10);

    // Bounce rejection on UP.
    cnt = 0;
    for (int t = 0; t < 8; t++) begin
      raw[0] = ~raw[0];
      for (int k = 0; k < 5; k++) begin
        step(1);
        if (press[0] || rel[0]) cnt++;
      end
    end
    chk_range("bounce_no_strobe", cnt, 0, 0);
    raw[0] = 1'b0;
    wait_strobe(0, 5'b00001, 40, n);
    chk_range("bounce_press_latency", n, 11, 14);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (press[0]) cnt++;
    end
    chk_range("bounce_single_press", cnt, 0, 0);
    raw[0] = 1'b1;
    step(20);

    // Simultaneous DN + BACK.
    raw[2:1] = 2'b00;
    wait_strobe(0, 5'b00110, 40, n);
    chk_vec("simul_press", press, 5'b00110);
    raw = '1;
    step(20);

    // Reset mid-debounce on INTERRUPT.
    raw[4] = 1'b0;
    step(6);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk_vec("midrst_level", level, 5'b00000);
    wait_strobe(0, 5'b10000, 40, n);
    chk_range("midrst_press_latency", n, 12, 12);
    raw = '1;
    step(20);

    // Auto-repeat on DN (long hold).
    raw[1] = 1'b0;
    wait_strobe(0, 5'b00010, 40, n);
    chk_range("hold_press_latency", n, 11, 14);
    cnt = 0; first = 0;
    for (int i = 1; i <= 160; i++) begin
      step(1);
      if (rpt[1]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    chk_range("repeat_first", first, RD * TD, RD * TD);
    chk_range("repeat_count", cnt, 18, 18);
`else
    chk_range("repeat_count_off", cnt, 0, 0);
`endif
    raw[1] = 1'b1;
    wait_strobe(1, 5'b00010, 40, n);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (rpt != '0) cnt++;
    end
    chk_range("repeat_after_release", cnt, 0, 0);

    // Randomized segments with occasional resets; model checks every cycle.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      raw = NB'($urandom);
      step($urandom_range(1, 24));
    end
    raw = '1;
    step(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_btn_conditioner
`default_nettype wire
